// File: rtl/dest_reg_pipeline.sv
// Destination-register select and in-flight tracker for the MIPS datapath.
// Carries {addr, we} through DEPTH stages with stall/flush and reports source-register hits.
module dest_reg_pipeline #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 3,
    parameter int SEL_W   = $clog2(NUM_SRC),
    parameter int DEPTH   = 3,
    parameter int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      reg_write,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [ADDR_W-1:0]         rs_addr,
    input  logic [ADDR_W-1:0]         rt_addr,
    output logic [DEPTH*ADDR_W-1:0]   stage_addr,
    output logic [DEPTH-1:0]          stage_we,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic                      wb_we,
    output logic [DEPTH-1:0]          rs_hit,
    output logic [DEPTH-1:0]          rt_hit,
    output logic                      rs_fwd_valid,
    output logic                      rt_fwd_valid,
    output logic [IDX_W-1:0]          rs_fwd_idx,
    output logic [IDX_W-1:0]          rt_fwd_idx
);

    logic [ADDR_W-1:0] addr_in;
    logic              we_in;
    logic              sel_ok;
    logic [ADDR_W-1:0] st_addr [DEPTH];
    logic [DEPTH-1:0]  st_we;

    // An out-of-range select yields a bubble; writes to r0 are never tracked.
    always_comb begin
        addr_in = '0;
        sel_ok  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(sel) == i) begin
                addr_in = src_addr[i*ADDR_W +: ADDR_W];
                sel_ok  = 1'b1;
            end
        end
        we_in = sel_ok & reg_write & (addr_in != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_addr[0] <= '0;
            st_we[0]   <= 1'b0;
        end else if (flush) begin
            st_addr[0] <= '0;
            st_we[0]   <= 1'b0;
        end else if (!stall) begin
            st_addr[0] <= addr_in;
            st_we[0]   <= we_in;
        end
    end

    genvar k;
    generate
        for (k = 1; k < DEPTH; k++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    st_addr[k] <= '0;
                    st_we[k]   <= 1'b0;
                end else if (k == 1 && stall) begin
                    st_addr[k] <= '0;
                    st_we[k]   <= 1'b0;
                end else begin
                    st_addr[k] <= st_addr[k-1];
                    st_we[k]   <= st_we[k-1];
                end
            end
        end

        for (k = 0; k < DEPTH; k++) begin : g_hit
            assign stage_addr[k*ADDR_W +: ADDR_W] = st_addr[k];
            assign rs_hit[k] = st_we[k] & (st_addr[k] == rs_addr) & (rs_addr != '0);
            assign rt_hit[k] = st_we[k] & (st_addr[k] == rt_addr) & (rt_addr != '0);
        end
    endgenerate

    assign stage_we     = st_we;
    assign wb_addr      = st_addr[DEPTH-1];
    assign wb_we        = st_we[DEPTH-1];
    assign rs_fwd_valid = |rs_hit;
    assign rt_fwd_valid = |rt_hit;

    // Scan oldest to youngest so the youngest hit overwrites.
    always_comb begin
        rs_fwd_idx = '0;
        rt_fwd_idx = '0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (rs_hit[j]) rs_fwd_idx = IDX_W'(j);
            if (rt_hit[j]) rt_fwd_idx = IDX_W'(j);
        end
    end

endmodule

// File: doc/dest_reg_pipeline.md
# dest_reg_pipeline

Parametrised write-destination selector and tracker for the MIPS datapath. It selects the destination register address from NUM_SRC candidate instruction fields, such as rt, rd or the constant 31 for jal. It then carries the address and its write-enable through DEPTH pipeline stages (EX/MEM/WB by default) with stall and flush control. It also compares two source-register queries against every in-flight destination, giving the hazard unit and forwarding muxes hit vectors and a youngest-match index.

## Interface
- ADDR_W, 5, register address width
- NUM_SRC, 3, number of candidate destination fields (≥2)
- SEL_W, $clog2(NUM_SRC), select width
- DEPTH, 3, tracked pipeline stages (≥1); stage 0 is youngest
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- src_addr  in  NUM_SRC*ADDR_W  candidate fields, candidate i at [i*ADDR_W +: ADDR_W]
- sel  in  SEL_W  candidate index
- reg_write  in  1  decoded write-enable of the incoming instruction
- stall  in  1  hold stage 0, insert bubble into stage 1
- flush  in  1  kill the instruction entering stage 0
- rs_addr, rt_addr  in  ADDR_W each  source-register queries
- stage_addr  out  DEPTH*ADDR_W  registered destination per stage
- stage_we  out  DEPTH  registered write-enable per stage
- wb_addr  out  ADDR_W  = stage_addr of stage DEPTH-1
- wb_we  out  1  = stage_we[DEPTH-1]
- rs_hit, rt_hit  out  DEPTH each  per-stage match flags
- rs_fwd_valid, rt_fwd_valid  out  1  any hit
- rs_fwd_idx, rt_fwd_idx  out  $clog2(DEPTH) (min 1 bit)  lowest (youngest) hit stage index; 0 when no hit

## Operation
- Candidate: addr_in = src_addr[sel]. If sel ≥ NUM_SRC: addr_in = 0 and we_in = 0. Otherwise we_in = reg_write.
- Normalisation: addr_in == 0 forces we_in = 0. Every bubble is addr 0, we 0.
- Each clk edge, stage k ≥ 2 loads stage k-1.
- Stage 1 loads a bubble if stall=1, otherwise stage 0.
- Stage 0 update:
  - flush=1: load bubble.
  - flush=0, stall=1: hold.
  - Otherwise: load {addr_in, we_in}.
- flush and stall together: stage 0 is cleared, stage 1 gets a bubble, and older stages advance.
- DEPTH=1: stall holds stage 0 and flush clears it.
- Hit: x_hit[k] = stage_we[k] & (stage_addr[k] == x_addr) & (x_addr != 0). Purely combinational from current registers and queries.
- fwd_idx: priority encoder, lowest k wins. fwd_valid = |x_hit.
- No state machine; the state is the DEPTH-entry shift register.

## Timing
- Reset (async assert, sync release on the next edge): all stage_addr = 0, stage_we = 0. Consequently wb_we = 0, all hits 0, fwd_valid 0 and fwd_idx 0.
- Latency: a value selected in cycle n appears at stage 0 after edge n+1 and at wb after edge n+DEPTH, each stall cycle adding one.
- Hit outputs are valid in the same cycle as the query, with no added register.
- Reset asserted mid-operation clears every stage immediately, independent of clk. In-flight writes are lost.

## Test plan
- Reset then propagate: rst_n low → all outputs 0. Release, then sel=1, src_addr={31,rd=9,rt=4}, reg_write=1 for one cycle, then bubbles (reg_write=0) → stage 0 = 9/we1 after edge 1; wb_addr=9, wb_we=1 after edge 3; wb_we=0 after edge 4.
- Zero/illegal select: sel=0 with rt=0 and reg_write=1 → stage_we[0]=0. sel=3 with NUM_SRC=3 → addr 0, we 0.
- Stall/flush: load 7, assert stall 2 cycles → stage 0 holds 7, stage 1 shows bubbles, 7 reaches wb 2 cycles late. stall+flush together → stage 0 and stage 1 both 0 after the edge.
- Hazard priority: stages hold {5,5,12} with all we=1, rs_addr=5, rt_addr=12 → rs_hit=3'b011, rs_fwd_idx=0, rt_hit=3'b100, rt_fwd_idx=2. rs_addr=0 → no hit even if a stage holds 0.
- we gating: stage 1 = addr 8 with we=0, rs_addr=8 → rs_hit=0, rs_fwd_valid=0.
- Async reset mid-stream: pull rst_n low between edges while stages are full → outputs clear without a clk edge. Parameter sweep DEPTH=1, NUM_SRC=2 repeats the stall/flush scenario.
